// File: rtl/rob_pkg.sv
// Reorder buffer shared widths and entry type. Pipeline widths come from
// micro_op.svh when it is included first; fallback values are defined here.
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif
`ifndef ARF_INT_INDEX_SIZE
`define ARF_INT_INDEX_SIZE 5
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 6
`endif

package rob_pkg;
    localparam int RENAME_WIDTH           = `RENAME_WIDTH;
    localparam int COMMIT_WIDTH           = `COMMIT_WIDTH;
    localparam int ARF_W                  = `ARF_INT_INDEX_SIZE;
    localparam int PRF_W                  = `PRF_INT_INDEX_SIZE;
    localparam int ROB_SIZE_DEFAULT       = 64;
    localparam int ROB_INDEX_SIZE_DEFAULT = $clog2(ROB_SIZE_DEFAULT);
    localparam int WB_WIDTH_DEFAULT       = 4;
    localparam int COMMIT_CNT_W           = $clog2(COMMIT_WIDTH + 1);
    localparam int DISP_CNT_W             = $clog2(RENAME_WIDTH + 1);

    typedef struct packed {
        logic             rd_valid;
        logic [ARF_W-1:0] rd;
        logic [PRF_W-1:0] prd;
        logic [PRF_W-1:0] prev_rd;
        logic             prev_rd_valid;
        logic             done;
        logic             mispredict;
    } rob_entry_t;
endpackage

// File: rtl/rob_commit_select.sv
// Combinational in-order commit selection over the head window of the ROB.
module rob_commit_select
    import rob_pkg::*;
(
    input  logic [COMMIT_WIDTH-1:0]       entry_valid,
    input  rob_entry_t [COMMIT_WIDTH-1:0] entry,
    output logic [COMMIT_WIDTH-1:0]       commit_mask,
    output logic [COMMIT_CNT_W-1:0]       commit_count,
    output logic                          recover_req
);
    logic open_s;

    // A lane commits only while every older lane committed; a mispredict closes the window after itself.
    always_comb begin
        commit_mask  = '0;
        commit_count = '0;
        recover_req  = 1'b0;
        open_s       = 1'b1;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (open_s && entry_valid[k] && entry[k].done) begin
                commit_mask[k] = 1'b1;
                commit_count   = commit_count + COMMIT_CNT_W'(1);
                recover_req    = recover_req | entry[k].mispredict;
                open_s         = ~entry[k].mispredict;
            end else begin
                open_s = 1'b0;
            end
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer between dispatch and commit.
// Optional saturating perf counters are enabled with ROB_PERF_COUNTERS_EN.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROB_SIZE       = ROB_SIZE_DEFAULT,
    parameter int ROB_INDEX_SIZE = $clog2(ROB_SIZE),
    parameter int WB_WIDTH       = WB_WIDTH_DEFAULT
)(
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [RENAME_WIDTH-1:0]                      dispatch_valid,
    input  logic [RENAME_WIDTH-1:0]                      dispatch_rd_valid,
    input  logic [RENAME_WIDTH-1:0][ARF_W-1:0]           dispatch_rd,
    input  logic [RENAME_WIDTH-1:0][PRF_W-1:0]           dispatch_prd,
    input  logic [RENAME_WIDTH-1:0][PRF_W-1:0]           dispatch_prev_rd,
    input  logic [RENAME_WIDTH-1:0]                      dispatch_prev_rd_valid,
    output logic                                         rob_ready,
    output logic [RENAME_WIDTH-1:0][ROB_INDEX_SIZE-1:0]  rob_index,
    input  logic [WB_WIDTH-1:0]                          wb_valid,
    input  logic [WB_WIDTH-1:0][ROB_INDEX_SIZE-1:0]      wb_rob_index,
    input  logic [WB_WIDTH-1:0]                          wb_mispredict,
    output logic [COMMIT_WIDTH-1:0]                      retire_valid,
    output logic [COMMIT_WIDTH-1:0][ARF_W-1:0]           retire_arf,
    output logic [COMMIT_WIDTH-1:0][PRF_W-1:0]           retire_prf,
    output logic [COMMIT_WIDTH-1:0]                      pre_prf_valid,
    output logic [COMMIT_WIDTH-1:0][PRF_W-1:0]           pre_prf,
    output logic                                         recover
`ifdef ROB_PERF_COUNTERS_EN
    ,
    output logic [31:0]                                  perf_commit_count,
    output logic [31:0]                                  perf_flush_count
`endif
);
    localparam int CNT_W = ROB_INDEX_SIZE + 1;
    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(ROB_SIZE);

    logic [ROB_INDEX_SIZE-1:0] head_r;
    logic [ROB_INDEX_SIZE-1:0] tail_r;
    logic [CNT_W-1:0]          count_r;
    logic [ROB_SIZE-1:0]       valid_r;
    rob_entry_t                entry_r [ROB_SIZE];

    logic [COMMIT_WIDTH-1:0][ROB_INDEX_SIZE-1:0] win_index_s;
    logic [COMMIT_WIDTH-1:0]                     win_valid_s;
    rob_entry_t [COMMIT_WIDTH-1:0]               win_entry_s;
    logic [COMMIT_WIDTH-1:0]                     commit_mask_s;
    logic [COMMIT_CNT_W-1:0]                     commit_count_s;
    logic                                        recover_s;
    logic                                        dispatch_fire_s;
    logic [DISP_CNT_W-1:0]                       lane_total_s;
    logic [DISP_CNT_W-1:0]                       dispatched_s;
    logic [RENAME_WIDTH-1:0][ROB_INDEX_SIZE-1:0] slot_s;
    logic [ROB_INDEX_SIZE-1:0]                   head_next_s;

    // Gather the head window that commit selection looks at.
    always_comb begin
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            win_index_s[k] = head_r + ROB_INDEX_SIZE'(k);
            win_valid_s[k] = valid_r[win_index_s[k]];
            win_entry_s[k] = entry_r[win_index_s[k]];
        end
    end

    rob_commit_select u_commit_select (
        .entry_valid  (win_valid_s),
        .entry        (win_entry_s),
        .commit_mask  (commit_mask_s),
        .commit_count (commit_count_s),
        .recover_req  (recover_s)
    );

    // Ready is judged on the registered occupancy only, so same-cycle commits do not count.
    assign rob_ready       = (SIZE_C - count_r) >= CNT_W'(RENAME_WIDTH);
    assign dispatch_fire_s = rob_ready & ~recover_s;
    assign dispatched_s    = dispatch_fire_s ? lane_total_s : '0;
    assign head_next_s     = head_r + ROB_INDEX_SIZE'(commit_count_s);
    assign recover         = recover_s;
    assign rob_index       = slot_s;

    // Pack valid dispatch lanes contiguously from tail in lane order.
    always_comb begin
        lane_total_s = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            slot_s[i]    = tail_r + ROB_INDEX_SIZE'(lane_total_s);
            lane_total_s = lane_total_s + DISP_CNT_W'(dispatch_valid[i]);
        end
    end

    // Retirement outputs, zeroed on lanes that do not commit.
    always_comb begin
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            retire_valid[k]  = commit_mask_s[k] & win_entry_s[k].rd_valid;
            retire_arf[k]    = commit_mask_s[k] ? win_entry_s[k].rd : '0;
            retire_prf[k]    = commit_mask_s[k] ? win_entry_s[k].prd : '0;
            pre_prf_valid[k] = commit_mask_s[k] & win_entry_s[k].rd_valid & win_entry_s[k].prev_rd_valid;
            pre_prf[k]       = commit_mask_s[k] ? win_entry_s[k].prev_rd : '0;
        end
    end

    // Pointer, occupancy and entry state: flush on recover, else commit, writeback and dispatch.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            valid_r <= '0;
            for (int e = 0; e < ROB_SIZE; e++) begin
                entry_r[e].done <= 1'b0;
            end
        end else if (recover_s) begin
            head_r  <= head_next_s;
            tail_r  <= head_next_s;
            count_r <= '0;
            valid_r <= '0;
        end else begin
            head_r  <= head_next_s;
            tail_r  <= tail_r + ROB_INDEX_SIZE'(dispatched_s);
            count_r <= count_r + CNT_W'(dispatched_s) - CNT_W'(commit_count_s);
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (commit_mask_s[k]) begin
                    valid_r[win_index_s[k]] <= 1'b0;
                end
            end
            for (int w = 0; w < WB_WIDTH; w++) begin
                if (wb_valid[w] && valid_r[wb_rob_index[w]]) begin
                    entry_r[wb_rob_index[w]].done       <= 1'b1;
                    entry_r[wb_rob_index[w]].mispredict <= entry_r[wb_rob_index[w]].mispredict | wb_mispredict[w];
                end
            end
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                if (dispatch_fire_s && dispatch_valid[i]) begin
                    valid_r[slot_s[i]] <= 1'b1;
                    entry_r[slot_s[i]] <= '{rd_valid:      dispatch_rd_valid[i],
                                            rd:            dispatch_rd[i],
                                            prd:           dispatch_prd[i],
                                            prev_rd:       dispatch_prev_rd[i],
                                            prev_rd_valid: dispatch_prev_rd_valid[i],
                                            done:          1'b0,
                                            mispredict:    1'b0};
                end
            end
        end
    end

`ifdef ROB_PERF_COUNTERS_EN
    logic [32:0] commit_sum_s;
    assign commit_sum_s = {1'b0, perf_commit_count} + 33'(commit_count_s);

    // Saturating commit and flush counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_commit_count <= 32'd0;
            perf_flush_count  <= 32'd0;
        end else begin
            perf_commit_count <= commit_sum_s[32] ? 32'hFFFF_FFFF : commit_sum_s[31:0];
            if (recover_s && (perf_flush_count != 32'hFFFF_FFFF)) begin
                perf_flush_count <= perf_flush_count + 32'd1;
            end
        end
    end
`endif
endmodule
